// File: rtl/fir_tap_sequencer.sv
// Serial single-multiplier FIR engine: 64-deep delay line, one MAC per cycle over the coefficient store.
// Optional output clamping when FIR_SATURATE_EN is defined; otherwise the result wraps.
module fir_tap_sequencer #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int AW   = 38
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [DW-1:0]      sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic [$clog2(TAPS)-1:0]   current_count,
  input  logic signed [CW-1:0]      coeff,
  output logic signed [DW-1:0]      sample_out,
  output logic                      out_valid,
  output logic                      sat_flag
);
  localparam int CNTW = $clog2(TAPS);
  localparam int PW   = DW + CW;
  localparam int FRAC = CW;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t                    state, state_nxt;
  logic [TAPS-1:0][DW-1:0]   dly;
  logic signed [PW-1:0]      prod;
  logic                      prod_vld;
  logic signed [AW-1:0]      acc;
  logic [DW-1:0]             res_nxt;
  logic                      accept;
  logic                      last_tap;

  assign sample_ready = (state == IDLE);
  assign accept       = sample_valid && sample_ready;
  assign last_tap     = (current_count == CNTW'(TAPS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) current_count <= '0;
    else if (state == MAC && !last_tap) current_count <= current_count + 1'b1;
    else current_count <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= '0;
    else if (accept) dly <= {dly[TAPS-2:0], sample_in};
  end

  // prod_vld keeps the stale product from the previous sample out of the first accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= (state == MAC);
      if (state == MAC) prod <= $signed(dly[current_count]) * coeff;
      if (accept) acc <= '0;
      else if (prod_vld) acc <= acc + $signed({{(AW-PW){prod[PW-1]}}, prod});
    end
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [AW-1:0] RMAX = AW'(2**(DW-1) - 1);
  localparam logic signed [AW-1:0] RMIN = -RMAX - 1;
  logic signed [AW-1:0] res_full;
  logic                 sat_nxt;

  assign res_full = acc >>> FRAC;

  always_comb begin
    res_nxt = acc[FRAC+DW-1:FRAC];
    sat_nxt = 1'b0;
    if (res_full > RMAX) begin
      res_nxt = {1'b0, {(DW-1){1'b1}}};
      sat_nxt = 1'b1;
    end else if (res_full < RMIN) begin
      res_nxt = {1'b1, {(DW-1){1'b0}}};
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else        sat_flag <= (state == OUT) && sat_nxt;
  end
`else
  logic acc_bits_unused;
  assign res_nxt         = acc[FRAC+DW-1:FRAC];
  assign sat_flag        = 1'b0;
  assign acc_bits_unused = ^{acc[AW-1:FRAC+DW], acc[FRAC-1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      if (state == OUT) sample_out <= res_nxt;
    end
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Serial single-multiplier FIR engine for one equalizer band. It accepts a 16-bit audio sample and keeps a 64-deep sample delay line. It then walks the band's coefficient store through `current_count` = 0..63, multiplying each returned `coeff` by the matching delayed sample and accumulating the products. It sits between the band's sample input and the band-sum stage, and is the only driver of the coefficient store's index.

## Interface
- `TAPS`, 64: number of taps (delay-line depth, count range 0..TAPS-1).
- `DW`, 16: sample width (signed Q1.15).
- `CW`, 16: coefficient width (signed, scale 2^-16).
- `AW`, 38: accumulator width (DW+CW+6 guard bits).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sample_in`  in  DW  signed input sample.
- `sample_valid`  in  1  input sample present.
- `sample_ready`  out  1  engine idle; a sample is accepted on an edge where valid && ready.
- `current_count`  out  6  tap index to the coefficient store.
- `coeff`  in  CW  signed coefficient returned combinationally for `current_count`.
- `sample_out`  out  DW  signed filtered sample.
- `out_valid`  out  1  one-cycle pulse; `sample_out` is valid.
- `sat_flag`  out  1  one-cycle pulse with `out_valid` when the result was clamped (saturation build only; otherwise tied 0).

## Operation
- Reset values: `sample_ready`=1, `current_count`=0, `sample_out`=0, `out_valid`=0, `sat_flag`=0. Delay line, accumulator and product register are cleared to 0 and the state is IDLE.
- States: IDLE → MAC → DRAIN → OUT → IDLE.
- IDLE: `sample_ready`=1 and `current_count`=0. On accept:
  - the delay line shifts, so x[0] = sample_in and x[i] = old x[i-1];
  - the accumulator clears;
  - the state goes to MAC.
- MAC: `current_count` runs 0..63, one per cycle.
  - Each cycle: prod <= x[current_count] * coeff, a signed 32-bit product into a register.
  - The accumulator adds the previous cycle's product, with the product sign-extended to AW.
  - After count 63 the state goes to DRAIN and `current_count` returns to 0.
- DRAIN: the accumulator adds the last product; the state goes to OUT.
- OUT: result = acc >>> 16 (arithmetic). Register `sample_out`, pulse `out_valid`, and go to IDLE.
- Width rule: result is truncated to DW by taking acc[31:16] (wrap) unless the saturation feature is compiled in.
- `sample_valid` while `sample_ready`=0 is ignored. The sample is not queued and the delay line is unchanged.
- `sample_out` holds its value until the next OUT.
- Async reset asserted mid-operation aborts immediately:
  - the partial result is discarded and no `out_valid` is produced;
  - the delay line is zeroed.

## Timing
- Let E0 be the accepting edge.
- `current_count`=k during the cycle after edge Ek (k=0..63).
- Products are registered at E1..E64. Accumulation happens at E2..E65.
- `sample_out`/`out_valid` update at E66, so `out_valid` is high during the cycle following E66.
- `sample_ready` is high in that same cycle. A sample offered then is accepted at E67.
- Throughput is one sample per 67 cycles.
- `coeff` must settle within one cycle of `current_count` changing; the store is combinational.

## Configuration
- `FIR_SATURATE_EN` defined:
  - if acc >>> 16 > 32767, `sample_out`=32767;
  - if it is < -32768, `sample_out`=-32768;
  - `sat_flag` pulses with `out_valid` on either clamp.
- Not defined: `sample_out` = acc[31:16] (two's-complement wrap) and `sat_flag` is constant 0.

## Test plan
- Impulse: feed 32767 then 63 zeros. Outputs follow (32767*coeff[n])>>>16 in order. First output −5 (coeff −10); output 32 is 4077 (coeff 0x1FDC).
- All-zero input for 10 samples → every `sample_out`=0, `sat_flag`=0, each `out_valid` exactly 67 cycles apart at full rate.
- Handshake: hold `sample_valid`=1 continuously with changing data. Only samples present when `sample_ready`=1 are accepted, and ignored samples never appear in the delay line (check via a following impulse response).
- Latency: accept at E0 → `out_valid` high only in the cycle after E66, and `current_count` sweeps 0..63 in cycles E0+1..E63+1.
- Saturation: for 64 samples, feed +32767 where the tap's coefficient is ≥0 and −32768 where it is <0.
  - With `FIR_SATURATE_EN`: `sample_out`=32767 and `sat_flag`=1.
  - Without it: the wrapped value is acc[31:16].
- Reset mid-MAC: drop `rst_n` at `current_count`=30. Outputs go to reset values asynchronously and no `out_valid` follows. A subsequent impulse yields the clean impulse response, with no stale samples.
